// File: rtl/debug_uart_rx.sv
// Debug-port 8N1 UART receiver: 16x oversampled start/bit/stop detection with majority voting,
// a 2-entry receive FIFO and sticky overrun / framing-error flags.
module debug_uart_rx (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_ref,
  input  logic       rx,
  input  logic       rd,
  input  logic       clr_err,
  output logic [7:0] rx_data,
  output logic       rx_avail,
  output logic       overrun,
  output logic       frame_err,
  output logic       break_det
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  logic       rx_meta, rx_s, ref_d, tick;
  state_e     state_q;
  logic [3:0] samp_cnt_q;
  logic [2:0] bit_cnt_q;
  logic [2:0] vote_q;
  logic [7:0] shreg_q;
  logic [7:0] head_q, tail_q;
  logic [1:0] cnt_q;
  logic       samp9, maj, stop_eval, push, ferr_set, pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      ref_d   <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      ref_d   <= baud_ref;
    end
  end

  assign tick = baud_ref ^ ref_d;

  // The stop bit is judged on the sample-9 tick itself, so the third vote comes straight from rx_s.
  assign samp9     = (samp_cnt_q == 4'd9) ? rx_s : vote_q[2];
  assign maj       = (vote_q[0] & vote_q[1]) | (vote_q[0] & samp9) | (vote_q[1] & samp9);
  assign stop_eval = tick && (state_q == StStop) && (samp_cnt_q == 4'd9);
  assign push      = stop_eval && maj;
  assign ferr_set  = stop_eval && !maj;
  assign pop       = rd && (cnt_q != 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      samp_cnt_q <= 4'd0;
      bit_cnt_q  <= 3'd0;
      vote_q     <= 3'd0;
      shreg_q    <= 8'h00;
      break_det  <= 1'b0;
    end else if (tick) begin
      if (state_q == StStart || state_q == StData || state_q == StStop) begin
        if (samp_cnt_q == 4'd7) vote_q[0] <= rx_s;
        if (samp_cnt_q == 4'd8) vote_q[1] <= rx_s;
        if (samp_cnt_q == 4'd9) vote_q[2] <= rx_s;
      end
      unique case (state_q)
        StIdle: begin
          if (!rx_s) begin
            state_q    <= StStart;
            samp_cnt_q <= 4'd1;
          end
        end
        StStart: begin
          samp_cnt_q <= samp_cnt_q + 4'd1;
          if (samp_cnt_q == 4'd15) begin
            if (maj) begin
              state_q <= StIdle;
            end else begin
              state_q    <= StData;
              bit_cnt_q  <= 3'd0;
              samp_cnt_q <= 4'd0;
            end
          end
        end
        StData: begin
          samp_cnt_q <= samp_cnt_q + 4'd1;
          if (samp_cnt_q == 4'd15) begin
            shreg_q   <= {maj, shreg_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q    <= StStop;
              samp_cnt_q <= 4'd0;
            end
          end
        end
        StStop: begin
          samp_cnt_q <= samp_cnt_q + 4'd1;
          if (samp_cnt_q == 4'd9) begin
            if (maj) begin
              state_q <= StIdle;
            end else begin
              state_q   <= StBreak;
              break_det <= 1'b1;
            end
          end
        end
        StBreak: begin
          if (rx_s) begin
            state_q   <= StIdle;
            break_det <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Empty FIFO keeps head at zero so rx_data reads 8'h00 with nothing buffered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q    <= 8'h00;
      tail_q    <= 8'h00;
      cnt_q     <= 2'd0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (push) begin
        unique case (cnt_q)
          2'd0: begin
            head_q <= shreg_q;
            cnt_q  <= 2'd1;
          end
          2'd1: begin
            if (pop) begin
              head_q <= shreg_q;
            end else begin
              tail_q <= shreg_q;
              cnt_q  <= 2'd2;
            end
          end
          default: begin
            if (pop) begin
              head_q <= tail_q;
              tail_q <= shreg_q;
            end
          end
        endcase
      end else if (pop) begin
        if (cnt_q == 2'd1) begin
          head_q <= 8'h00;
          cnt_q  <= 2'd0;
        end else begin
          head_q <= tail_q;
          tail_q <= 8'h00;
          cnt_q  <= 2'd1;
        end
      end

      if (push && (cnt_q == 2'd2) && !pop) overrun <= 1'b1;
      else if (clr_err)                    overrun <= 1'b0;

      if (ferr_set)     frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
    end
  end

  assign rx_data  = head_q;
  assign rx_avail = (cnt_q != 2'd0);

endmodule

// File: tb/tb_debug_uart_rx.sv
// Directed bench for debug_uart_rx: 13-clk tick generator, 208-clk bit frames, immediate-assert checks.
module tb_debug_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_ref = 1'b0;
  logic       rx = 1'b1;
  logic       rd = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rx_data;
  logic       rx_avail, overrun, frame_err, break_det;

  int checks = 0;
  int errors = 0;
  int bdiv = 0;

  debug_uart_rx dut (
    .clk       (clk),
    .rst       (rst),
    .baud_ref  (baud_ref),
    .rx        (rx),
    .rd        (rd),
    .clr_err   (clr_err),
    .rx_data   (rx_data),
    .rx_avail  (rx_avail),
    .overrun   (overrun),
    .frame_err (frame_err),
    .break_det (break_det)
  );

  always #5 clk = ~clk;

  // Baud generator with preload 8'h0C: one baud_ref edge every 13 clk.
  always @(posedge clk) begin
    #2;
    if (bdiv == 12) begin
      bdiv     = 0;
      baud_ref = ~baud_ref;
    end else begin
      bdiv++;
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Frame starts on a negedge in the same cycle as a baud_ref toggle, which puts the STOP
  // sample-9 push on the posedge between negedges 2002 and 2003 of the frame.
  task automatic send(input logic [7:0] data, input logic stop, input bit pop_at_push);
    logic [9:0] fr;
    int n;
    fr = {stop, data, 1'b0};
    n  = 0;
    @(negedge clk);
    while (bdiv != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    rx = fr[0];
    for (int k = 1; k <= 2080; k++) begin
      @(negedge clk);
      if ((k % 208 == 0) && (k < 2080)) rx = fr[k / 208];
      if (pop_at_push) rd = (k == 2002);
    end
    rd = 1'b0;
  endtask

  task automatic pop_one();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_avail", {7'd0, rx_avail}, 8'h00);
    chk("rst_ovr", {7'd0, overrun}, 8'h00);
    chk("rst_ferr", {7'd0, frame_err}, 8'h00);
    chk("rst_brk", {7'd0, break_det}, 8'h00);
    rst = 1'b0;
    repeat (50) @(negedge clk);

    send(8'h55, 1'b1, 1'b0);
    chk("b55_avail", {7'd0, rx_avail}, 8'h01);
    chk("b55_data", rx_data, 8'h55);
    chk("b55_ovr", {7'd0, overrun}, 8'h00);
    chk("b55_ferr", {7'd0, frame_err}, 8'h00);
    pop_one();
    chk("b55_pop_avail", {7'd0, rx_avail}, 8'h00);
    chk("b55_pop_data", rx_data, 8'h00);

    rx = 1'b0;
    repeat (39) @(negedge clk);
    rx = 1'b1;
    repeat (416) @(negedge clk);
    chk("fs_avail", {7'd0, rx_avail}, 8'h00);
    chk("fs_brk", {7'd0, break_det}, 8'h00);
    send(8'hA3, 1'b1, 1'b0);
    chk("a3_avail", {7'd0, rx_avail}, 8'h01);
    chk("a3_data", rx_data, 8'hA3);
    pop_one();

    send(8'h11, 1'b1, 1'b0);
    send(8'h22, 1'b1, 1'b0);
    chk("ovr_full_noovr", {7'd0, overrun}, 8'h00);
    send(8'h33, 1'b1, 1'b0);
    chk("ovr_set", {7'd0, overrun}, 8'h01);
    chk("ovr_head", rx_data, 8'h11);
    pop_one();
    chk("ovr_pop1", rx_data, 8'h22);
    chk("ovr_pop1_avail", {7'd0, rx_avail}, 8'h01);
    pop_one();
    chk("ovr_pop2_avail", {7'd0, rx_avail}, 8'h00);
    chk("ovr_pop2_data", rx_data, 8'h00);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("ovr_clr", {7'd0, overrun}, 8'h00);

    send(8'h11, 1'b1, 1'b0);
    send(8'h22, 1'b1, 1'b0);
    send(8'h44, 1'b1, 1'b1);
    chk("sim_ovr", {7'd0, overrun}, 8'h00);
    chk("sim_head", rx_data, 8'h22);
    chk("sim_avail", {7'd0, rx_avail}, 8'h01);
    pop_one();
    chk("sim_pop1", rx_data, 8'h44);
    pop_one();
    chk("sim_pop2_avail", {7'd0, rx_avail}, 8'h00);

    send(8'hA5, 1'b0, 1'b0);
    repeat (20 * 208) @(negedge clk);
    chk("fe_ferr", {7'd0, frame_err}, 8'h01);
    chk("fe_brk", {7'd0, break_det}, 8'h01);
    chk("fe_avail", {7'd0, rx_avail}, 8'h00);
    chk("fe_ovr", {7'd0, overrun}, 8'h00);
    rx = 1'b1;
    repeat (16) @(negedge clk);
    chk("fe_brk_rel", {7'd0, break_det}, 8'h00);
    repeat (400) @(negedge clk);
    send(8'h5A, 1'b1, 1'b0);
    chk("5a_avail", {7'd0, rx_avail}, 8'h01);
    chk("5a_data", rx_data, 8'h5A);
    chk("5a_ferr_sticky", {7'd0, frame_err}, 8'h01);

    // Mid-frame reset during data bit 4 of 8'hFF, with 8'h5A still buffered.
    rx = 1'b0;
    repeat (208) @(negedge clk);
    rx = 1'b1;
    repeat (4 * 208 + 104) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mr_data", rx_data, 8'h00);
    chk("mr_avail", {7'd0, rx_avail}, 8'h00);
    chk("mr_ferr", {7'd0, frame_err}, 8'h00);
    chk("mr_ovr", {7'd0, overrun}, 8'h00);
    chk("mr_brk", {7'd0, break_det}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (3 * 208) @(negedge clk);
    chk("mr_idle_avail", {7'd0, rx_avail}, 8'h00);
    send(8'h0F, 1'b1, 1'b0);
    chk("0f_avail", {7'd0, rx_avail}, 8'h01);
    chk("0f_data", rx_data, 8'h0F);
    chk("0f_ferr", {7'd0, frame_err}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
